sdram_bank_timer: RTL and testbench

SDRAM_BANK_TIMER -- requirements
Module: sdram_bank_timer

---
 rtl/sdram_bank_timer_if.sv | 29 ++
 rtl/sdram_bank_timer.sv | 174 +++++++++++++++++
 tb/tb_sdram_bank_timer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sdram_bank_timer_if.sv
// Command/status bundle between an SDRAM command scheduler and the bank timer.
// Latency/backpressure: none of its own; the bank timer's ok flags gate the scheduler.
interface sdram_bank_timer_if #(
  parameter int NBANK = 4,
  parameter int RAW   = 12,
  parameter int BAW   = (NBANK > 1) ? $clog2(NBANK) : 1
);
  logic                  cmd_valid;
  logic [2:0]            cmd_type;
  logic [BAW-1:0]        cmd_ba;
  logic [RAW-1:0]        cmd_row;
  logic [NBANK-1:0]      act_ok;
  logic [NBANK-1:0]      rw_ok;
  logic [NBANK-1:0]      pre_ok;
  logic                  ref_ok;
  logic [NBANK-1:0]      bank_open;
  logic [NBANK*RAW-1:0]  open_row;
  logic                  cmd_err;

  modport master (
    output cmd_valid, cmd_type, cmd_ba, cmd_row,
    input  act_ok, rw_ok, pre_ok, ref_ok, bank_open, open_row, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_ba, cmd_row,
    output act_ok, rw_ok, pre_ok, ref_ok, bank_open, open_row, cmd_err
  );
endinterface

// File: rtl/sdram_bank_timer.sv
// SDRAM bank timing tracker: ok flags are combinational from state, cmd_err is a +1 cycle pulse.
// No backpressure: illegal commands are dropped and flagged, never stalled.
module sdram_bank_timer #(
  parameter int CLK_FREQ = 133,
  parameter int NBANK    = 4,
  parameter int RAW      = 12,
  parameter int tRAS     = 37,
  parameter int tRC      = 60,
  parameter int tRCD     = 15,
  parameter int tRFC     = 66,
  parameter int tRP      = 15,
  parameter int tRRD     = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  sdram_bank_timer_if.slave  bus
);

  function automatic int to_cyc(input int t_ns);
    int c;
    c = (t_ns * CLK_FREQ + 999) / 1000;
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int C_RCD = to_cyc(tRCD);
  localparam int C_RAS = to_cyc(tRAS);
  localparam int C_RC  = to_cyc(tRC);
  localparam int C_RP  = to_cyc(tRP);
  localparam int C_RRD = to_cyc(tRRD);
  localparam int C_RFC = to_cyc(tRFC);
  localparam int C_MAX = imax(imax(imax(C_RCD, C_RAS), imax(C_RC, C_RP)), imax(C_RRD, C_RFC));
  localparam int CW    = $clog2(C_MAX + 1);

  // Load value is cX-1 so the dependent command may issue exactly cX cycles later.
  localparam logic [CW-1:0] L_RCD = CW'(C_RCD - 1);
  localparam logic [CW-1:0] L_RAS = CW'(C_RAS - 1);
  localparam logic [CW-1:0] L_RC  = CW'(C_RC - 1);
  localparam logic [CW-1:0] L_RP  = CW'(C_RP - 1);
  localparam logic [CW-1:0] L_RRD = CW'(C_RRD - 1);
  localparam logic [CW-1:0] L_RFC = CW'(C_RFC - 1);

  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;
  localparam logic [2:0] CMD_REF  = 3'd6;

  function automatic logic [CW-1:0] dec(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - CW'(1);
  endfunction

  logic [NBANK-1:0][CW-1:0]  rcd_q, rcd_d, ras_q, ras_d, rc_q, rc_d, rp_q, rp_d;
  logic [CW-1:0]             rrd_q, rrd_d, rfc_q, rfc_d;
  logic [NBANK-1:0]          bank_open_q, bank_open_d;
  logic [NBANK-1:0][RAW-1:0] open_row_q, open_row_d;
  logic                      cmd_err_q, cmd_err_d;

  logic [NBANK-1:0] act_ok, rw_ok, pre_ok;
  logic             ref_ok;
  logic             legal;

  always_comb begin
    act_ok = '0;
    rw_ok  = '0;
    pre_ok = '0;
    ref_ok = (rfc_q == '0);
    for (int b = 0; b < NBANK; b++) begin
      act_ok[b] = !bank_open_q[b] && (rc_q[b] == '0) && (rp_q[b] == '0) &&
                  (rrd_q == '0) && (rfc_q == '0);
      rw_ok[b]  = bank_open_q[b] && (rcd_q[b] == '0);
      pre_ok[b] = !bank_open_q[b] || (ras_q[b] == '0);
      if (bank_open_q[b] || (rp_q[b] != '0) || (rc_q[b] != '0)) begin
        ref_ok = 1'b0;
      end
    end
  end

  always_comb begin
    legal = 1'b1;
    case (bus.cmd_type)
      CMD_ACT:         legal = act_ok[bus.cmd_ba];
      CMD_RD, CMD_WR:  legal = rw_ok[bus.cmd_ba];
      CMD_PRE:         legal = pre_ok[bus.cmd_ba];
      CMD_PREA:        legal = &pre_ok;
      CMD_REF:         legal = ref_ok;
      default:         legal = 1'b1;
    endcase
  end

  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      rcd_d[b] = dec(rcd_q[b]);
      ras_d[b] = dec(ras_q[b]);
      rc_d[b]  = dec(rc_q[b]);
      rp_d[b]  = dec(rp_q[b]);
    end
    rrd_d       = dec(rrd_q);
    rfc_d       = dec(rfc_q);
    bank_open_d = bank_open_q;
    open_row_d  = open_row_q;
    cmd_err_d   = 1'b0;

    if (bus.cmd_valid) begin
      cmd_err_d = !legal;
      if (legal) begin
        case (bus.cmd_type)
          CMD_ACT: begin
            bank_open_d[bus.cmd_ba] = 1'b1;
            open_row_d[bus.cmd_ba]  = bus.cmd_row;
            rcd_d[bus.cmd_ba]       = L_RCD;
            ras_d[bus.cmd_ba]       = L_RAS;
            rc_d[bus.cmd_ba]        = L_RC;
            rrd_d                   = L_RRD;
          end
          // PRE to a closed bank is a no-op and must not restart tRP.
          CMD_PRE: begin
            if (bank_open_q[bus.cmd_ba]) begin
              bank_open_d[bus.cmd_ba] = 1'b0;
              rp_d[bus.cmd_ba]        = L_RP;
            end
          end
          CMD_PREA: begin
            for (int b = 0; b < NBANK; b++) begin
              if (bank_open_q[b]) begin
                bank_open_d[b] = 1'b0;
                rp_d[b]        = L_RP;
              end
            end
          end
          CMD_REF: rfc_d = L_RFC;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcd_q       <= '0;
      ras_q       <= '0;
      rc_q        <= '0;
      rp_q        <= '0;
      rrd_q       <= '0;
      rfc_q       <= '0;
      bank_open_q <= '0;
      open_row_q  <= '0;
      cmd_err_q   <= 1'b0;
    end else begin
      rcd_q       <= rcd_d;
      ras_q       <= ras_d;
      rc_q        <= rc_d;
      rp_q        <= rp_d;
      rrd_q       <= rrd_d;
      rfc_q       <= rfc_d;
      bank_open_q <= bank_open_d;
      open_row_q  <= open_row_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign bus.act_ok    = act_ok;
  assign bus.rw_ok     = rw_ok;
  assign bus.pre_ok    = pre_ok;
  assign bus.ref_ok    = ref_ok;
  assign bus.bank_open = bank_open_q;
  assign bus.open_row  = open_row_q;
  assign bus.cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_sdram_bank_timer.sv
// Directed bench for sdram_bank_timer at default parameters (133 MHz, 4 banks, 12-bit rows).
// A command driven in one clock period is checked in the following period, sampled on the falling edge.
module tb_sdram_bank_timer;

  localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3,
                         PRE = 3'd4, PREA = 3'd5, REFC = 3'd6, RSV = 3'd7;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sdram_bank_timer_if #(.NBANK(4), .RAW(12)) bus ();

  sdram_bank_timer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [2:0]  t;
    logic [1:0]  ba;
    logic [11:0] row;
    logic [3:0]  e_act;
    logic [3:0]  e_rw;
    logic [3:0]  e_pre;
    logic        e_ref;
    logic [3:0]  e_open;
    logic [47:0] e_rows;
    logic        e_err;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic v, input logic [2:0] t, input logic [1:0] ba,
                              input logic [11:0] row, input logic [3:0] e_act,
                              input logic [3:0] e_rw, input logic [3:0] e_pre,
                              input logic e_ref, input logic [3:0] e_open,
                              input logic [47:0] e_rows, input logic e_err);
    vec_t r;
    r.v = v; r.t = t; r.ba = ba; r.row = row;
    r.e_act = e_act; r.e_rw = e_rw; r.e_pre = e_pre; r.e_ref = e_ref;
    r.e_open = e_open; r.e_rows = e_rows; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive a command for one period; returns on the falling edge of the next period.
  task automatic issue(input logic v, input logic [2:0] t, input logic [1:0] ba,
                       input logic [11:0] row);
    bus.cmd_valid = v;
    bus.cmd_type  = t;
    bus.cmd_ba    = ba;
    bus.cmd_row   = row;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = NOP;
    bus.cmd_ba    = 2'd0;
    bus.cmd_row   = 12'd0;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, NOP, 2'd0, 12'd0);
  endtask

  task automatic do_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = NOP;
    bus.cmd_ba    = 2'd0;
    bus.cmd_row   = 12'd0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;

    vecs[0]  = mk(1, ACT,  2'd0, 12'h123, 4'b0000, 4'b0000, 4'b1110, 0, 4'b0001, 48'h000000_000123, 0);
    vecs[1]  = mk(1, ACT,  2'd1, 12'h3FF, 4'b1110, 4'b0001, 4'b1110, 0, 4'b0001, 48'h000000_000123, 1);
    vecs[2]  = mk(1, ACT,  2'd1, 12'h0AB, 4'b0000, 4'b0001, 4'b1100, 0, 4'b0011, 48'h000000_0AB123, 0);
    vecs[3]  = mk(0, NOP,  2'd0, 12'h000, 4'b1100, 4'b0011, 4'b1100, 0, 4'b0011, 48'h000000_0AB123, 0);
    vecs[4]  = mk(1, RSV,  2'd2, 12'h555, 4'b1100, 4'b0011, 4'b1101, 0, 4'b0011, 48'h000000_0AB123, 0);
    vecs[5]  = mk(1, RD,   2'd2, 12'h000, 4'b1100, 4'b0011, 4'b1101, 0, 4'b0011, 48'h000000_0AB123, 1);
    vecs[6]  = mk(1, PRE,  2'd1, 12'h000, 4'b1100, 4'b0011, 4'b1111, 0, 4'b0011, 48'h000000_0AB123, 1);
    vecs[7]  = mk(1, PRE,  2'd0, 12'h000, 4'b1100, 4'b0010, 4'b1111, 0, 4'b0010, 48'h000000_0AB123, 0);
    vecs[8]  = mk(1, WR,   2'd1, 12'h000, 4'b1101, 4'b0010, 4'b1111, 0, 4'b0010, 48'h000000_0AB123, 0);
    vecs[9]  = mk(1, PREA, 2'd0, 12'h000, 4'b1101, 4'b0000, 4'b1111, 0, 4'b0000, 48'h000000_0AB123, 0);
    vecs[10] = mk(1, REFC, 2'd0, 12'h000, 4'b1111, 4'b0000, 4'b1111, 1, 4'b0000, 48'h000000_0AB123, 1);
    vecs[11] = mk(0, NOP,  2'd0, 12'h000, 4'b1111, 4'b0000, 4'b1111, 1, 4'b0000, 48'h000000_0AB123, 0);

    // Reset state, checked while reset is held and right after release.
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = NOP;
    bus.cmd_ba    = 2'd0;
    bus.cmd_row   = 12'd0;
    rst_n = 1'b0;
    #12;
    chk("rst_act_ok", bus.act_ok, 4'b1111);
    chk("rst_rw_ok", bus.rw_ok, 4'b0000);
    chk("rst_pre_ok", bus.pre_ok, 4'b1111);
    chk("rst_ref_ok", bus.ref_ok, 1'b1);
    chk("rst_open", bus.bank_open, 4'b0000);
    chk("rst_rows", bus.open_row, 48'h0);
    chk("rst_err", bus.cmd_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].v, vecs[i].t, vecs[i].ba, vecs[i].row);
      chk($sformatf("v%0d_act_ok", i), bus.act_ok, vecs[i].e_act);
      chk($sformatf("v%0d_rw_ok", i), bus.rw_ok, vecs[i].e_rw);
      chk($sformatf("v%0d_pre_ok", i), bus.pre_ok, vecs[i].e_pre);
      chk($sformatf("v%0d_ref_ok", i), bus.ref_ok, vecs[i].e_ref);
      chk($sformatf("v%0d_open", i), bus.bank_open, vecs[i].e_open);
      chk($sformatf("v%0d_rows", i), bus.open_row, vecs[i].e_rows);
      chk($sformatf("v%0d_err", i), bus.cmd_err, vecs[i].e_err);
    end

    // tRCD / tRAS / tRC after an ACT, PRE at T+5, re-ACT at T+8.
    do_reset();
    issue(1'b1, ACT, 2'd0, 12'h123);
    chk("s1_open_t1", bus.bank_open[0], 1'b1);
    chk("s1_row_t1", bus.open_row[11:0], 12'h123);
    chk("s1_rw_t1", bus.rw_ok[0], 1'b0);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("s1_pre_t%0d", k), bus.pre_ok[0], 1'b0);
      if (k == 2) chk("s1_rw_t2", bus.rw_ok[0], 1'b1);
      nop(1);
    end
    chk("s1_pre_t5", bus.pre_ok[0], 1'b1);
    issue(1'b1, PRE, 2'd0, 12'h0);
    chk("s1_closed_t6", bus.bank_open[0], 1'b0);
    chk("s1_row_hold_t6", bus.open_row[11:0], 12'h123);
    chk("s1_act_t6", bus.act_ok[0], 1'b0);
    nop(1);
    chk("s1_act_t7", bus.act_ok[0], 1'b0);
    nop(1);
    chk("s1_act_t8", bus.act_ok[0], 1'b1);
    issue(1'b1, ACT, 2'd0, 12'h456);
    chk("s1_react_open", bus.bank_open[0], 1'b1);
    chk("s1_react_err", bus.cmd_err, 1'b0);
    chk("s1_react_row", bus.open_row[11:0], 12'h456);

    // PREA across banks 0 and 2 followed by REF and the tRFC lockout.
    do_reset();
    issue(1'b1, ACT, 2'd0, 12'h111);
    nop(1);
    issue(1'b1, ACT, 2'd2, 12'h2CD);
    chk("s2_act2_err", bus.cmd_err, 1'b0);
    chk("s2_open_02", bus.bank_open, 4'b0101);
    nop(5);
    chk("s2_pre_ok_all", bus.pre_ok, 4'b1111);
    issue(1'b1, PREA, 2'd0, 12'h0);
    chk("s2_prea_open", bus.bank_open, 4'b0000);
    chk("s2_prea_ref_t1", bus.ref_ok, 1'b0);
    nop(1);
    chk("s2_ref_ok_t2", bus.ref_ok, 1'b1);
    issue(1'b1, REFC, 2'd0, 12'h0);
    chk("s2_ref_err", bus.cmd_err, 1'b0);
    for (int k = 3; k <= 10; k++) begin
      chk($sformatf("s2_rfc_act_t%0d", k), bus.act_ok, 4'b0000);
      nop(1);
    end
    chk("s2_rfc_act_t11", bus.act_ok, 4'b1111);

    // Reset pulsed mid-tRAS discards all history.
    do_reset();
    issue(1'b1, ACT, 2'd3, 12'hABC);
    chk("s3_open3", bus.bank_open, 4'b1000);
    chk("s3_row3", bus.open_row[47:36], 12'hABC);
    nop(1);
    rst_n = 1'b0;
    #2;
    chk("s3_in_rst_open", bus.bank_open, 4'b0000);
    chk("s3_in_rst_rows", bus.open_row, 48'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("s3_rel_act", bus.act_ok, 4'b1111);
    chk("s3_rel_pre", bus.pre_ok, 4'b1111);
    chk("s3_rel_ref", bus.ref_ok, 1'b1);
    chk("s3_rel_rw", bus.rw_ok, 4'b0000);
    issue(1'b1, ACT, 2'd3, 12'h321);
    chk("s3_first_cmd_open", bus.bank_open, 4'b1000);
    chk("s3_first_cmd_err", bus.cmd_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
